// File: rtl/host_reg_bridge_pkg.sv
// Shared constants for the host register bridge: opcodes, response codes,
// FSM state encoding and frame byte counts.
package host_reg_bridge_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_WR  = 8'h01;
  localparam logic [7:0] OP_RD  = 8'h02;

  localparam logic [7:0] RSP_WR_ACK = 8'h81;
  localparam logic [7:0] RSP_RD     = 8'h82;
  localparam logic [7:0] RSP_ERR    = 8'hFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ADDR    = 3'd1;
  localparam state_t ST_DATA    = 3'd2;
  localparam state_t ST_WR_STB  = 3'd3;
  localparam state_t ST_RD_STB  = 3'd4;
  localparam state_t ST_RD_WAIT = 3'd5;
  localparam state_t ST_RESP    = 3'd6;

  localparam int ADDR_BYTES  = 4;
  localparam int DATA_BYTES  = 4;
  localparam int RESP_BYTES  = 5;   // widest response: code + 4 read-data bytes
  localparam int RD_RESP_LEN = 5;
  localparam int ACK_LEN     = 1;

endpackage

// File: rtl/host_reg_bridge_resp_serializer.sv
// Response byte serializer: loads up to RESP_BYTES bytes (first byte in the
// top lane) plus a count, and hands them out one per tx handshake.
module host_reg_bridge_resp_serializer
  import host_reg_bridge_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [8*RESP_BYTES-1:0] load_bytes,
  input  logic [2:0]              load_len,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last
);

  logic [8*RESP_BYTES-1:0] sh_q;
  logic [2:0]              left_q;

  assign tx_data  = sh_q[8*RESP_BYTES-1 -: 8];
  assign tx_valid = (left_q != 3'd0);
  assign tx_last  = (left_q == 3'd1);

  // Shift register advances one byte per accepted transfer; holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_q   <= '0;
      left_q <= 3'd0;
    end else if (load) begin
      sh_q   <= load_bytes;
      left_q <= load_len;
    end else if (tx_valid && tx_ready) begin
      sh_q   <= {sh_q[8*RESP_BYTES-9:0], 8'h00};
      left_q <= left_q - 3'd1;
    end
  end

endmodule

// File: rtl/host_reg_bridge.sv
// Host register bridge: decodes framed command bytes from the host byte
// stream into single-cycle register-bus strobes and returns responses.
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for opcode byte
// ADDR       | collecting 4 address bytes, MSB first
// DATA       | collecting 4 write-data bytes, MSB first
// WR_STB     | wr_strobe cycle
// RD_STB     | rd_strobe cycle
// RD_WAIT    | waiting RD_LAT cycles for slave read data
// RESP       | serializer sending response bytes
module host_reg_bridge
  import host_reg_bridge_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [30:0] addr_bus,
  output logic [31:0] data_bus_wr,
  input  logic [31:0] data_bus_rd,
  output logic        wr_strobe,
  output logic        rd_strobe,
  output logic        busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [1:0]              byte_cnt_q;
  logic                    is_rd_q;
  logic [TMO_W-1:0]        tmo_q;
  logic [1:0]              lat_q;
  logic                    rx_xfer;
  logic                    tmo_hit;
  logic                    addr_last;
  logic                    data_last;
  logic                    loading;
  logic                    ser_load;
  logic [8*RESP_BYTES-1:0] ser_bytes;
  logic [2:0]              ser_len;
  logic                    tx_last;

  assign rx_xfer   = rx_valid && rx_ready;
  assign loading   = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign tmo_hit   = loading && !rx_xfer && (tmo_q == TMO_W'(1));
  assign addr_last = (byte_cnt_q == 2'(ADDR_BYTES - 1));
  assign data_last = (byte_cnt_q == 2'(DATA_BYTES - 1));

  assign wr_strobe = (state_q == ST_WR_STB);
  assign rd_strobe = (state_q == ST_RD_STB);
  assign busy      = (state_q != ST_IDLE);

  // Next-state decode and response loading.
  always_comb begin
    state_d   = state_q;
    ser_load  = 1'b0;
    ser_bytes = '0;
    ser_len   = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (rx_xfer) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_d = ST_ADDR;
          end else if (rx_data != OP_NOP) begin
            state_d   = ST_RESP;
            ser_load  = 1'b1;
            ser_bytes = {RSP_ERR, 32'h0};
            ser_len   = 3'(ACK_LEN);
          end
        end
      end
      ST_ADDR: begin
        if (rx_xfer && addr_last) state_d = is_rd_q ? ST_RD_STB : ST_DATA;
        else if (tmo_hit)         state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (rx_xfer && data_last) state_d = ST_WR_STB;
        else if (tmo_hit)         state_d = ST_IDLE;
      end
      ST_WR_STB: begin
        state_d   = ST_RESP;
        ser_load  = 1'b1;
        ser_bytes = {RSP_WR_ACK, 32'h0};
        ser_len   = 3'(ACK_LEN);
      end
      ST_RD_STB: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d   = ST_RESP;
          ser_load  = 1'b1;
          ser_bytes = {RSP_RD, data_bus_rd};
          ser_len   = 3'(RD_RESP_LEN);
        end
      end
      ST_RESP: begin
        if (tx_valid && tx_ready && tx_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; rx_ready is registered from the next state so it is low in reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rx_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_ready <= (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    end
  end

  // Frame bookkeeping: opcode kind and byte position within the field.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_rd_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
    end else if (state_q == ST_IDLE && rx_xfer) begin
      is_rd_q    <= (rx_data == OP_RD);
      byte_cnt_q <= 2'd0;
    end else if (loading && rx_xfer) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  // Bus registers only move while bytes are being loaded; top address bit falls off.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_bus    <= '0;
      data_bus_wr <= '0;
    end else if (rx_xfer) begin
      if (state_q == ST_ADDR) addr_bus    <= {addr_bus[22:0], rx_data};
      if (state_q == ST_DATA) data_bus_wr <= {data_bus_wr[23:0], rx_data};
    end
  end

  // Inter-byte timeout down-counter, reloaded on every transfer and outside a frame.
  always_ff @(posedge clk) begin
    if (!reset_n)                tmo_q <= TMO_W'(TIMEOUT);
    else if (!loading || rx_xfer) tmo_q <= TMO_W'(TIMEOUT);
    else                         tmo_q <= tmo_q - TMO_W'(1);
  end

  // Read latency down-counter; capture happens when it reaches zero in RD_WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n)                                lat_q <= 2'd0;
    else if (state_q == ST_RD_STB)               lat_q <= 2'(RD_LAT - 1);
    else if (state_q == ST_RD_WAIT && lat_q != 0) lat_q <= lat_q - 2'd1;
  end

  host_reg_bridge_resp_serializer u_resp_serializer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (ser_load),
    .load_bytes (ser_bytes),
    .load_len   (ser_len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last)
  );

endmodule

// File: tb/tb_host_reg_bridge.sv
// Directed bench for host_reg_bridge with a registered-read slave model.
module tb_host_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [30:0] addr_bus;
  logic [31:0] data_bus_wr;
  logic [31:0] data_bus_rd;
  logic        wr_strobe;
  logic        rd_strobe;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0;
  int          wr_cyc = 0, rd_cyc = 0;
  logic [30:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] slave_val = '0;
  logic [7:0]  txq[$];
  int          txc[$];
  int          last_xfer = 0;

  host_reg_bridge #(.RD_LAT(1), .TIMEOUT(50000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .addr_bus    (addr_bus),
    .data_bus_wr (data_bus_wr),
    .data_bus_rd (data_bus_rd),
    .wr_strobe   (wr_strobe),
    .rd_strobe   (rd_strobe),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Slave with one cycle of registered read latency; zero when not driving.
  always @(posedge clk) data_bus_rd <= rd_strobe ? slave_val : 32'h0;

  // Bus and tx monitor, time-stamped with the edge index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_strobe) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= addr_bus;
      wr_data <= data_bus_wr;
      wr_cyc  <= cyc;
    end
    if (rd_strobe) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= addr_bus;
      rd_cyc  <= cyc;
    end
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      tick(1);
      n++;
    end
    tick(1);
    last_xfer = cyc - 1;
    rx_valid  = 1'b0;
    check("rx_accept", (n < 100), 1'b1);
  endtask

  task automatic send_n(input logic [7:0] b [9], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    check("tx_wait", (txq.size() >= n), 1'b1);
  endtask

  function automatic logic [39:0] tx5();
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 5 && i < txq.size(); i++) v = {v[31:0], txq[i]};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable;
    int k;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(3);
    check("reset_outputs",
          {rx_ready, tx_valid, tx_data, addr_bus, data_bus_wr, wr_strobe, rd_strobe, busy}, '0);
    reset_n = 1'b1;
    tick(1);
    check("idle_rx_ready", rx_ready, 1'b1);

    // Write to LED block
    send_n('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05}, 9);
    wait_tx(1);
    tick(3);
    check("wr_cnt", wr_cnt, 1);
    check("wr_addr", wr_addr, 31'h0100_0000);
    check("wr_data", wr_data, 32'h5);
    check("wr_latency", wr_cyc, last_xfer + 1);
    check("wr_tx_len", txq.size(), 1);
    check("wr_tx_byte", txq[0], 8'h81);
    check("wr_ack_latency", txc[0], wr_cyc + 1);
    check("wr_no_read", rd_cnt, 0);

    // Read
    txq.delete(); txc.delete();
    slave_val = 32'h0000_0005;
    send_n('{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    wait_tx(5);
    tick(3);
    check("rd_cnt", rd_cnt, 1);
    check("rd_addr", rd_addr, 31'h0100_0000);
    check("rd_latency", rd_cyc, last_xfer + 1);
    check("rd_tx_len", txq.size(), 5);
    check("rd_tx_bytes", tx5(), 40'h82_0000_0005);
    check("rd_tx_latency", txc[0], rd_cyc + 2);
    check("rd_keeps_wr_data", data_bus_wr, 32'h5);
    check("rd_no_write", wr_cnt, 1);

    // NOP padding then bad opcode, followed by a normal write
    txq.delete(); txc.delete();
    send_n('{8'h00, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    wait_tx(1);
    tick(3);
    check("bad_tx_len", txq.size(), 1);
    check("bad_tx_byte", txq[0], 8'hFF);
    check("bad_no_strobe", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd1, 8'd1});
    txq.delete(); txc.delete();
    send_n('{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 9);
    wait_tx(1);
    tick(3);
    check("wr2_cnt", wr_cnt, 2);
    check("wr2_addr", wr_addr, 31'h0000_0010);
    check("wr2_data", wr_data, 32'hDEAD_BEEF);
    check("wr2_tx", {txq.size(), txq[0]}, {32'd1, 8'h81});

    // Timeout in the address phase
    txq.delete(); txc.delete();
    send_n('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    tick(49990);
    check("tmo_busy_before", busy, 1'b1);
    tick(12);
    check("tmo_busy_after", busy, 1'b0);
    check("tmo_no_strobe", {wr_cnt[7:0], rd_cnt[7:0]}, {8'd2, 8'd1});
    check("tmo_no_tx", txq.size(), 0);
    check("tmo_rx_ready", rx_ready, 1'b1);

    // Read with address bit 31 set, under tx backpressure
    txq.delete(); txc.delete();
    slave_val = 32'hCAFE_0123;
    tx_ready  = 1'b0;
    send_n('{8'h02, 8'h81, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    k = 0;
    while (!tx_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("bp_tx_valid", tx_valid, 1'b1);
    check("bp_addr", addr_bus, 31'h0100_0004);
    check("bp_rd_cnt", rd_cnt, 2);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid && tx_data == 8'h82) stable++;
      tick(1);
    end
    check("bp_stable", stable, 20);
    check("bp_no_tx", txq.size(), 0);
    tx_ready = 1'b1;
    wait_tx(5);
    tick(3);
    check("bp_tx_len", txq.size(), 5);
    check("bp_tx_bytes", tx5(), 40'h82_CAFE_0123);
    check("bp_keeps_wr_data", data_bus_wr, 32'hDEAD_BEEF);

    // Reset after two of five response bytes
    txq.delete(); txc.delete();
    slave_val = 32'h1234_5678;
    send_n('{8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    k = 0;
    while (txq.size() < 2 && k < 50) begin
      tick(1);
      k++;
    end
    check("mid_two_bytes", txq.size(), 2);
    reset_n  = 1'b0;
    tx_ready = 1'b0;
    tick(1);
    check("mid_reset_outputs",
          {rx_ready, tx_valid, tx_data, addr_bus, data_bus_wr, wr_strobe, rd_strobe, busy}, '0);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    tick(20);
    check("mid_no_more_tx", txq.size(), 2);
    check("mid_first_bytes", {txq[0], txq[1]}, 16'h8212);
    txq.delete(); txc.delete();
    send_n('{8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'hAA}, 9);
    wait_tx(1);
    tick(3);
    check("post_reset_wr", {wr_cnt[7:0], wr_addr, wr_data}, {8'd3, 31'h30, 32'hAA});
    check("post_reset_tx", {txq.size(), txq[0]}, {32'd1, 8'h81});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_reg_bridge.md
Name: host_reg_bridge

Overview:
- Upstream bus master for the register slaves (LED block at 0x0100xxxx and its peers).
- Receives framed command bytes from the host byte-stream interface (FIFO side of the USB bridge) and turns them into single-cycle register-bus write and read strobes.
- Returns acknowledge and read-data bytes on an outbound byte stream.
- Owns the shared addr_bus, data_bus_wr, wr_strobe and rd_strobe. Slave read data arrives OR-combined on data_bus_rd.

Parameters:
- RD_LAT, 1: cycles from the rd_strobe cycle to valid data_bus_rd. Slaves register their read data. Legal range 1..4.
- TIMEOUT, 50000: idle cycles allowed between bytes inside a frame before the frame is aborted. 1 ms at 50 MHz.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous reset, active-low
- rx_data  in  8  inbound command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data; a byte transfers on rx_valid&rx_ready
- tx_data  out  8  outbound response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts; a byte transfers on tx_valid&tx_ready
- addr_bus  out  31  register address
- data_bus_wr  out  32  write data
- data_bus_rd  in  32  OR of slave read data; zero when no slave is driving
- wr_strobe  out  1  one-cycle write strobe
- rd_strobe  out  1  one-cycle read strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All outputs go to 0, state goes to IDLE.
  - This applies mid-frame and mid-response: the partial frame is discarded and no tx byte follows.
- Frame format:
  - Opcode byte, then 4 address bytes MSB first. Bit 7 of the first address byte is dropped, giving addr_bus[30:0].
  - Write only: 4 data bytes MSB first.
- Opcodes:
  - 0x00: NOP/resync padding, consumed with no response.
  - 0x01: write.
  - 0x02: read.
  - Any other value: single response byte 0xFF, then IDLE.
- States: IDLE, ADDR, DATA, WR_STB, RD_STB, RD_WAIT, RESP.
- IDLE: rx_ready=1. On a transfer, the opcode is decoded:
  - 0x01 or 0x02 -> ADDR with byte count 0.
  - 0x00 -> stay in IDLE.
  - Other -> RESP, loaded with 0xFF.
- ADDR: rx_ready=1. Each byte shifts into the address register. After the 4th byte:
  - write -> DATA.
  - read -> RD_STB.
- DATA: rx_ready=1. Bytes shift into the data register. After the 4th byte -> WR_STB.
- WR_STB:
  - rx_ready=0 here and in every later state.
  - wr_strobe=1 for exactly one cycle.
  - Next state: RESP, loaded with 0x81.
- RD_STB: rd_strobe=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT: data_bus_rd is captured in the cycle RD_LAT cycles after the strobe cycle. Then RESP, loaded with 0x82 followed by the 4 data bytes MSB first (5 bytes total).
- RESP:
  - tx_valid=1. tx_data is held stable until tx_ready.
  - The next byte is presented in the cycle after each transfer.
  - After the last transfer -> IDLE.
  - A tx_ready stall of any length is legal and never times out.
- Bus hold: addr_bus and data_bus_wr change only while loading in ADDR/DATA. They hold their values from the strobe cycle until the next frame loads.
  - Read frames leave data_bus_wr unchanged.
- Timeout:
  - In ADDR/DATA, a counter increments each cycle without an rx transfer and clears on each transfer.
  - When the count reaches TIMEOUT: state -> IDLE, frame discarded, no strobe, no response.
- Back-to-back frames: the first byte of the next frame is accepted in the cycle IDLE is re-entered. Commands therefore never overlap.
- Latencies:
  - Last rx byte of a write -> wr_strobe on the next cycle.
  - wr_strobe -> tx_valid on the next cycle.
  - Read: rd_strobe -> tx_valid after RD_LAT+1 cycles.

Decomposition:
- Package host_reg_bridge_pkg holds:
  - opcodes: OP_NOP=0x00, OP_WR=0x01, OP_RD=0x02;
  - response codes: RSP_WR_ACK=0x81, RSP_RD=0x82, RSP_ERR=0xFF;
  - the state enum;
  - the frame byte counts.
- One sub-module, resp_serializer: loads up to 5 bytes plus a length, and drives tx_data/tx_valid under the tx_ready handshake.

Test Plan:
- Write to LED: rx 01 01 00 00 00 00 00 00 05 -> one wr_strobe cycle with addr_bus=31'h0100_0000 and data_bus_wr=32'h5, then tx 0x81.
- Read: rx 02 01 00 00 00, with the bench driving data_bus_rd=32'h0000_0005 one cycle after rd_strobe (RD_LAT=1) -> tx 82 00 00 00 05.
- Bad opcode and resync: rx 00 00 7E -> no strobe, tx single byte FF. A following valid write completes normally.
- Timeout: rx 01 01 00, then silence for 50000 cycles -> busy falls, no strobe, no tx. The next frame works.
- Backpressure and bit 31: read with address bytes 81 00 00 04 -> addr_bus=31'h0100_0004. tx_ready held low for 20 cycles: tx_data stays at 0x82 throughout, and no byte is lost or duplicated.
- Reset mid-response: assert reset_n=0 after 2 of 5 read-response bytes -> next cycle all outputs are 0, state IDLE, and no further tx bytes.
